add_sub: RTL and testbench

- Registered 16-bit unsigned adder/subtractor with a runtime-selectable active width.
- Subtraction returns sign-magnitude: the magnitude |a−b| plus a separate negative flag.
- Serves as the mantissa add/subtract stage of the half-precision floating-point adder datapath.
- The core is a parallel-prefix (doubling-recursion) carry network.

---
 rtl/add_sub_pkg.sv | 19 +
 rtl/add_sub_prefix_adder.sv | 45 ++++
 rtl/add_sub.sv | 108 ++++++++++
 tb/tb_add_sub.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared constants and helpers for the registered mantissa adder/subtractor.
// Operand width, length-port width, opcode encodings and effective-width decode.
package add_sub_pkg;

  localparam int unsigned W  = 16;
  localparam int unsigned LW = 5;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // A zero or oversized len selects the full datapath width.
  function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] l);
    if (l == '0 || int'(l) > int'(W)) begin
      return LW'(W);
    end
    return l;
  endfunction

endpackage

// File: rtl/add_sub_prefix_adder.sv
// Combinational Kogge-Stone adder with carry-in; exposes every bit's carry-out.
// c[i] is the carry out of bit i-1, so c[Width] is the full-width carry.
module add_sub_prefix_adder #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] x,
  input  logic [Width-1:0] y,
  input  logic             cin,
  output logic [Width-1:0] sum,
  output logic [Width:1]   c
);

  localparam int unsigned Levels = $clog2(Width);

  logic [Width-1:0] prop;
  logic [Width-1:0] g [Levels+1];
  logic [Width-1:0] p [Levels];

  assign prop = x ^ y;

  // Folding cin into bit 0's generate makes every prefix carry include it.
  assign g[0] = {x[Width-1:1] & y[Width-1:1], (x[0] & y[0]) | (prop[0] & cin)};
  assign p[0] = prop;

  for (genvar l = 0; l < Levels; l++) begin : g_level
    localparam int unsigned Dist = 1 << l;
    for (genvar i = 0; i < Width; i++) begin : g_bit
      if (i >= Dist) begin : g_merge
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-Dist]);
        if (l < Levels - 1) begin : g_prop
          assign p[l+1][i] = p[l][i] & p[l][i-Dist];
        end
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        if (l < Levels - 1) begin : g_prop
          assign p[l+1][i] = p[l][i];
        end
      end
    end
  end

  assign sum = prop ^ {g[Levels][Width-2:0], cin};
  assign c   = g[Levels];

endmodule

// File: rtl/add_sub.sv
// Registered unsigned add / sign-magnitude subtract over a runtime-selected width.
// Mantissa add/subtract stage of the half-precision floating-point adder.
module add_sub
  import add_sub_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          sgn,
  input  logic [LW-1:0] len,
  output logic [W-1:0]  ans,
  output logic          neg,
  output logic          cout
);

  logic [LW-1:0] n;
  logic [W-1:0]  mask;
  logic [W-1:0]  a_m;
  logic [W-1:0]  b_m;
  logic [W-1:0]  y;
  logic          cin;
  logic [W-1:0]  d_raw;
  logic [W-1:0]  d;
  logic [W:1]    c_main;
  logic          carry;
  logic [W-1:0]  nd_raw;
  logic [W:1]    c_neg;
  logic          unused_neg_carries;

  logic [W-1:0]  ans_d, ans_q;
  logic          neg_d, neg_q;
  logic          cout_d, cout_q;

  assign n = eff_len(len);

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(W); i++) begin
      mask[i] = (i < int'(n));
    end
  end

  assign a_m = a & mask;
  assign b_m = b & mask;
  assign y   = (sgn == OP_ADD) ? b_m : ~b_m;
  assign cin = (sgn == OP_SUB);

  add_sub_prefix_adder #(
    .Width (W)
  ) u_main (
    .x   (a_m),
    .y   (y),
    .cin (cin),
    .sum (d_raw),
    .c   (c_main)
  );

  // Bits above n are garbage from ~b_m; the carry at n-1 does not see them.
  assign d     = d_raw & mask;
  assign carry = c_main[n];

  add_sub_prefix_adder #(
    .Width (W)
  ) u_neg (
    .x   (~d),
    .y   ({W{1'b0}}),
    .cin (1'b1),
    .sum (nd_raw),
    .c   (c_neg)
  );

  assign unused_neg_carries = ^c_neg;

  always_comb begin
    ans_d  = d;
    neg_d  = 1'b0;
    cout_d = 1'b0;
    unique case (sgn)
      OP_ADD: cout_d = carry;
      OP_SUB: begin
        // No borrow-free carry means a_m < b_m; report |d| with a sign flag.
        if (!carry) begin
          ans_d = nd_raw & mask;
          neg_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ans_q  <= '0;
      neg_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      ans_q  <= ans_d;
      neg_q  <= neg_d;
      cout_q <= cout_d;
    end
  end

  assign ans  = ans_q;
  assign neg  = neg_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub: directed cases plus random ops against an
// arithmetic reference model.
module tb_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        sgn;
  logic [4:0]  len;
  logic [15:0] ans;
  logic        neg;
  logic        cout;

  int checks = 0;
  int errors = 0;

  add_sub dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .sgn  (sgn),
    .len  (len),
    .ans  (ans),
    .neg  (neg),
    .cout (cout)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the masked operands.
  function automatic void model(input logic [15:0] ia, input logic [15:0] ib, input logic isgn,
                                input logic [4:0] ilen, output logic [15:0] eans,
                                output logic eneg, output logic ecout);
    int    nn;
    longint m, am, bm, s;
    nn = (ilen == 0 || ilen > 16) ? 16 : int'(ilen);
    m  = (longint'(1) << nn) - 1;
    am = longint'(ia) & m;
    bm = longint'(ib) & m;
    if (isgn) begin
      s     = am + bm;
      eans  = 16'(s & m);
      ecout = s > m;
      eneg  = 1'b0;
    end else begin
      ecout = 1'b0;
      if (am >= bm) begin
        eans = 16'(am - bm);
        eneg = 1'b0;
      end else begin
        eans = 16'(bm - am);
        eneg = 1'b1;
      end
    end
  endfunction

  task automatic step(input logic [15:0] ia, input logic [15:0] ib, input logic isgn,
                      input logic [4:0] ilen);
    a   = ia;
    b   = ib;
    sgn = isgn;
    len = ilen;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(16'hFFFF, 16'hFFFF, 1'b1, 5'd16);
    checks++;
    if ({ans, neg, cout} !== {16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: ans=%h neg=%b cout=%b, want ans=0000 neg=0 cout=0", ans, neg, cout);
    end
    rst = 1'b0;
    step(16'hFFFF, 16'hFFFF, 1'b1, 5'd16);
    checks++;
    if ({ans, neg, cout} !== {16'hFFFE, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_release: ans=%h neg=%b cout=%b, want ans=fffe neg=0 cout=1",
               ans, neg, cout);
    end
  endtask

  task automatic test_add();
    logic [15:0] xa [9] = '{0, 1, 3, 11, 783, 783, 783, 86, 5560};
    logic [15:0] xb [9] = '{0, 0, 3, 7, 15, 47, 139, 93, 8101};
    logic [15:0] xr [9] = '{0, 1, 6, 18, 798, 830, 922, 179, 13661};
    for (int i = 0; i < 9; i++) begin
      step(xa[i], xb[i], 1'b1, 5'd16);
      checks++;
      if ({ans, neg, cout} !== {xr[i], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL add %0d+%0d: ans=%0d neg=%b cout=%b, want ans=%0d neg=0 cout=0",
                 xa[i], xb[i], ans, neg, cout, xr[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [15:0] xa [6] = '{61560, 1560, 1260, 1260, 100, 0};
    logic [15:0] xb [6] = '{60101, 100, 1101, 2101, 100, 65535};
    logic [15:0] xr [6] = '{1459, 1460, 159, 841, 0, 65535};
    logic        xn [6] = '{0, 0, 0, 1, 0, 1};
    for (int i = 0; i < 6; i++) begin
      step(xa[i], xb[i], 1'b0, 5'd16);
      checks++;
      if ({ans, neg, cout} !== {xr[i], xn[i], 1'b0}) begin
        errors++;
        $display("FAIL sub %0d-%0d: ans=%0d neg=%b cout=%b, want ans=%0d neg=%b cout=0",
                 xa[i], xb[i], ans, neg, cout, xr[i], xn[i]);
      end
    end
  endtask

  task automatic test_overflow();
    step(16'd65535, 16'd1, 1'b1, 5'd16);
    checks++;
    if ({ans, neg, cout} !== {16'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_65535+1: ans=%0d neg=%b cout=%b, want ans=0 neg=0 cout=1",
               ans, neg, cout);
    end
    step(16'd61560, 16'd60101, 1'b1, 5'd16);
    checks++;
    if ({ans, neg, cout} !== {16'd56125, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_61560+60101: ans=%0d neg=%b cout=%b, want ans=56125 neg=0 cout=1",
               ans, neg, cout);
    end
  endtask

  task automatic test_mask();
    step(16'h01F0, 16'h0020, 1'b1, 5'd8);
    checks++;
    if ({ans, neg, cout} !== {16'h0010, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mask_add8: ans=%h neg=%b cout=%b, want ans=0010 neg=0 cout=1",
               ans, neg, cout);
    end
    step(16'h0110, 16'h0020, 1'b0, 5'd8);
    checks++;
    if ({ans, neg, cout} !== {16'h0010, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mask_sub8: ans=%h neg=%b cout=%b, want ans=0010 neg=1 cout=0",
               ans, neg, cout);
    end
    step(16'd65535, 16'd1, 1'b1, 5'd0);
    checks++;
    if ({ans, neg, cout} !== {16'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL len0_add: ans=%0d neg=%b cout=%b, want ans=0 neg=0 cout=1", ans, neg, cout);
    end
    step(16'd1260, 16'd2101, 1'b0, 5'd0);
    checks++;
    if ({ans, neg, cout} !== {16'd841, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL len0_sub: ans=%0d neg=%b cout=%b, want ans=841 neg=1 cout=0", ans, neg, cout);
    end
    step(16'hFFFF, 16'h0003, 1'b1, 5'd1);
    checks++;
    if ({ans, neg, cout} !== {16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL len1_add: ans=%h neg=%b cout=%b, want ans=0000 neg=0 cout=1", ans, neg, cout);
    end
  endtask

  // New inputs must not reach outputs before the next edge.
  task automatic test_back_to_back();
    logic [15:0] eans;
    logic        eneg, ecout;
    step(16'd5560, 16'd8101, 1'b1, 5'd16);
    a   = 16'd0;
    b   = 16'd65535;
    sgn = 1'b0;
    #2;
    checks++;
    if ({ans, neg, cout} !== {16'd13661, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hold: ans=%0d neg=%b cout=%b, want ans=13661 neg=0 cout=0", ans, neg, cout);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({ans, neg, cout} !== {16'd65535, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_next: ans=%0d neg=%b cout=%b, want ans=65535 neg=1 cout=0",
               ans, neg, cout);
    end
    for (int i = 0; i < 12; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      step(ra, rb, i[0], 5'd16);
      model(ra, rb, i[0], 5'd16, eans, eneg, ecout);
      checks++;
      if ({ans, neg, cout} !== {eans, eneg, ecout}) begin
        errors++;
        $display("FAIL b2b %h %h sgn=%b: ans=%h neg=%b cout=%b, want ans=%h neg=%b cout=%b",
                 ra, rb, i[0], ans, neg, cout, eans, eneg, ecout);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb, eans;
    logic [4:0]  rl;
    logic        rs, eneg, ecout;
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      rl = 5'($urandom_range(0, 31));
      if (i % 8 == 0) rb = ra;
      step(ra, rb, rs, rl);
      model(ra, rb, rs, rl, eans, eneg, ecout);
      checks++;
      if ({ans, neg, cout} !== {eans, eneg, ecout}) begin
        errors++;
        $display("FAIL rand a=%h b=%h sgn=%b len=%0d: ans=%h neg=%b cout=%b, want %h %b %b",
                 ra, rb, rs, rl, ans, neg, cout, eans, eneg, ecout);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;
    b   = '0;
    sgn = 1'b1;
    len = 5'd16;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_mask();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
